ctrl_pipe_stages: RTL and testbench
===================================

# ctrl_pipe_stages

Parametrised, clocked control-signal pipeline carrying the decoded control bundle from ID through the STAGES downstream pipeline stages. The default is EX, MEM and WB. Each stage is a register with a valid bit and per-stage flush. The block adds a global freeze and a multi-cycle hazard-bubble sequencer that replaces a single-cycle bubble mux. It sits between the controller and the datapath pipeline registers, and drives the front-end `Stall` used by the PC and IF/ID.

## Interface
- `WIDTH`, 16: control bundle width in bits (ALUSrc, RegDst, RegWrite, ALUOp, MemRead, MemWrite, MemToReg, …, packed by the top level).
- `STAGES`, 3: number of control stages; must be ≥ 1.
- `LEN_W`, 3: width of the bubble-length request.

Ports:
- `Clk` in 1: single clock, rising edge.
- `Rst` in 1: asynchronous, active-low reset.
- `in_ctrl` in WIDTH: decoded control bundle from the controller (ID stage).
- `in_valid` in 1: ID holds a real instruction.
- `Hazard` in 1: hazard detected in ID; request bubbles.
- `Hazard_len` in LEN_W: number of bubbles requested; 0 is treated as 1.
- `Flush` in STAGES: per-stage squash; bit k clears stage k at the next edge.
- `Freeze` in 1: hold every stage and the sequencer (back-end stall, e.g. memory wait).
- `out_ctrl` out STAGES*WIDTH: stage k occupies bits [k*WIDTH +: WIDTH]; stage 0 is EX.
- `out_valid` out STAGES: per-stage valid.
- `Stall` out 1: front-end hold; PC and IF/ID must not update.

## Operation
Sequencer states:
- `IDLE`
- `BUBBLE`, with down-counter `cnt` of width LEN_W.

Per-edge priority (highest first): `Rst` > `Freeze` > `Flush[k]` > bubble insertion > normal advance.

**Freeze**
- All stage registers, `state` and `cnt` hold.
- `Stall` = 1.

**Normal advance**
- Stage 0 loads `{in_ctrl, in_valid}`.
- Stage k loads stage k-1.

**Flush[k]**
- Stage k loads ctrl = 0, valid = 0, instead of its normal input.
- Other stages behave normally.

**Bubble insertion**
- In `IDLE` with `Hazard` = 1, stage 0 loads ctrl = 0, valid = 0; stages 1..STAGES-1 advance.
- With effective length N = max(`Hazard_len`, 1): if N > 1, go to `BUBBLE` with `cnt` = N-1; else stay in `IDLE`.
- In `BUBBLE`, stage 0 loads a bubble and `cnt` decrements. At `cnt` = 1, return to `IDLE` on that edge.
- `Hazard` asserted while in `BUBBLE` is ignored; there is no retrigger or extension.

**Stall**
- `Stall` = `Freeze` | (`state` == `BUBBLE`) | (`state` == `IDLE` & `Hazard`).
- Combinational, so IF/ID holds on the same edge the first bubble enters.

**Flush[0] during BUBBLE**
- Stage 0 is cleared.
- `state` returns to `IDLE` and `cnt` = 0. The stalled instruction is being squashed by a branch.

**Bubble contents**
- Every bubble is all-zero ctrl with valid = 0.
- Downstream logic treats ctrl = 0 as a NOP: no RegWrite, MemRead or MemWrite.

## Timing
**Reset**
- All `out_ctrl` = 0, all `out_valid` = 0, `state` = `IDLE`, `cnt` = 0, `Stall` = 0.
- Reset is asynchronous on the falling edge of `Rst`. It takes effect mid-sequence, discarding any pending bubbles.

**Latency**
- `in_ctrl` appears on stage 0 one edge after sampling.
- It reaches stage k after k+1 edges, excluding frozen cycles.

**Stall duration**
- A hazard of effective length N holds `Stall` high for exactly N non-frozen cycles and inserts exactly N bubbles.
- `Freeze` during `BUBBLE` pauses `cnt`; bubble count and duration are preserved.

**Simultaneous events**
- `Freeze` with `Flush`: the flush is lost. The hazard unit must hold `Flush` until `Freeze` drops.
- `Hazard` with `Flush[0]` in `IDLE`: stage 0 is cleared and the sequencer stays in `IDLE`, so no bubbles are inserted.

**Outputs**
- All outputs except `Stall` are registered.

## Configuration
- `CTRL_PIPE_STATS_EN`
  - Defined: adds output `bubble_cnt` (32 bits, reset 0). It increments on every non-frozen edge where stage 0 loads a hazard bubble, and saturates at 0xFFFF_FFFF. Flush-induced clears are not counted.
  - Undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- Reset and advance:
  - Stimulus: `Rst` low then high; drive `in_ctrl` = 16'hA5A5 with `in_valid` = 1 for one cycle.
  - Required response: outputs 0 during reset. Stage 0/1/2 show A5A5 with valid set on edges 1/2/3.
- Three-bubble hazard:
  - Stimulus: `Hazard` = 1 with `Hazard_len` = 3 for one cycle, in `IDLE`.
  - Required response: `Stall` high for exactly 3 cycles. Stage 0 valid = 0 on three consecutive edges, then resumes `in_ctrl`. With stats enabled, `bubble_cnt` = 3.
- Freeze mid-bubble:
  - Stimulus: `Hazard_len` = 4; `Freeze` for 2 cycles after the second bubble.
  - Required response: all stages hold during freeze. `Stall` is high for 6 cycles total. Exactly 4 bubbles are inserted.
- Branch squash during bubble:
  - Stimulus: `Flush[0]` = 1 in the 2nd cycle of a `Hazard_len` = 5 sequence.
  - Required response: state returns to `IDLE`, `Stall` drops the next cycle, and stage 0 valid = 0.
- Reset mid-sequence and zero-length request:
  - Stimulus: `Rst` low during `BUBBLE`; later, `Hazard_len` = 0.
  - Required response: immediate all-zero outputs with `Stall` = 0. The zero-length request behaves as a single bubble.

Source files
------------

// File: rtl/ctrl_pipe_stages.sv
// ctrl_pipe_stages: control-bundle pipeline with freeze, per-stage flush and a multi-bubble hazard sequencer; optional bubble_cnt under `CTRL_PIPE_STATS_EN
module ctrl_pipe_stages #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter int LEN_W  = 3
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [WIDTH-1:0]        in_ctrl,
  input  logic                    in_valid,
  input  logic                    Hazard,
  input  logic [LEN_W-1:0]        Hazard_len,
  input  logic [STAGES-1:0]       Flush,
  input  logic                    Freeze,
  output logic [STAGES*WIDTH-1:0] out_ctrl,
  output logic [STAGES-1:0]       out_valid,
  output logic                    Stall
`ifdef CTRL_PIPE_STATS_EN
  ,
  output logic [31:0]             bubble_cnt
`endif
);
  typedef enum logic {IDLE, BUBBLE} state_t;
  state_t state;
  logic [LEN_W-1:0] cnt;
  logic bubble;
  logic [LEN_W-1:0] eff_len;
  // Hazard is only honoured in IDLE, but BUBBLE inserts regardless, so the OR covers both
  always_comb begin
    bubble  = (state == BUBBLE) || Hazard;
    Stall   = Freeze || bubble;
    eff_len = (Hazard_len == '0) ? LEN_W'(1) : Hazard_len;
  end
  // Stage registers: flush beats bubble beats normal advance; freeze holds everything
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      out_ctrl  <= '0;
      out_valid <= '0;
    end else if (!Freeze) begin
      out_ctrl[0 +: WIDTH] <= (Flush[0] || bubble) ? '0 : in_ctrl;
      out_valid[0]         <= !Flush[0] && !bubble && in_valid;
      for (int k = 1; k < STAGES; k++) begin
        out_ctrl[k*WIDTH +: WIDTH] <= Flush[k] ? '0 : out_ctrl[(k-1)*WIDTH +: WIDTH];
        out_valid[k]               <= !Flush[k] && out_valid[k-1];
      end
    end
  end
  // Bubble sequencer: cnt holds the bubbles still owed after the current one
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!Freeze) begin
      if (Flush[0]) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (state == IDLE) begin
        if (Hazard && eff_len > LEN_W'(1)) begin
          state <= BUBBLE;
          cnt   <= eff_len - LEN_W'(1);
        end
      end else if (cnt == LEN_W'(1)) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt - LEN_W'(1);
      end
    end
  end
`ifdef CTRL_PIPE_STATS_EN
  // Saturating count of hazard bubbles actually loaded into stage 0
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) bubble_cnt <= '0;
    else if (!Freeze && !Flush[0] && bubble && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_ctrl_pipe_stages.sv
// tb_ctrl_pipe_stages: table vectors, hand sequences and randomized run against a pending-bubble model
module tb_ctrl_pipe_stages;
  localparam int W = 16;
  localparam int S = 3;
  localparam int L = 3;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic [W-1:0] in_ctrl = '0;
  logic in_valid = 1'b0;
  logic Hazard = 1'b0;
  logic [L-1:0] Hazard_len = '0;
  logic [S-1:0] Flush = '0;
  logic Freeze = 1'b0;
  logic [S*W-1:0] out_ctrl;
  logic [S-1:0] out_valid;
  logic Stall;
`ifdef CTRL_PIPE_STATS_EN
  logic [31:0] bubble_cnt;
`endif
  ctrl_pipe_stages #(.WIDTH(W), .STAGES(S), .LEN_W(L)) dut (
    .Clk(Clk), .Rst(Rst), .in_ctrl(in_ctrl), .in_valid(in_valid),
    .Hazard(Hazard), .Hazard_len(Hazard_len), .Flush(Flush), .Freeze(Freeze),
    .out_ctrl(out_ctrl), .out_valid(out_valid), .Stall(Stall)
`ifdef CTRL_PIPE_STATS_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );
  always #5 Clk = ~Clk;
  int tests = 0;
  int fails = 0;
  logic [W-1:0] m_ctrl [S];
  logic m_valid [S];
  int m_pend;
  int m_bub;
  typedef struct {
    logic [W-1:0] c;
    logic v;
    logic h;
    logic [L-1:0] len;
    logic [S-1:0] fl;
    logic fz;
    logic es;
    logic [W-1:0] ec;
    logic [S-1:0] ev;
  } vec_t;
  vec_t tbl [22];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < S; k++) begin
      m_ctrl[k] = '0;
      m_valid[k] = 1'b0;
    end
    m_pend = 0;
    m_bub = 0;
  endtask
  task automatic model_edge();
    logic start;
    logic ins;
    if (!Freeze) begin
      start = (m_pend == 0) && Hazard;
      ins = (m_pend > 0) || start;
      for (int k = S - 1; k > 0; k--) begin
        m_ctrl[k] = Flush[k] ? '0 : m_ctrl[k-1];
        m_valid[k] = Flush[k] ? 1'b0 : m_valid[k-1];
      end
      if (Flush[0]) begin
        m_ctrl[0] = '0;
        m_valid[0] = 1'b0;
        m_pend = 0;
      end else if (ins) begin
        m_ctrl[0] = '0;
        m_valid[0] = 1'b0;
        m_pend = start ? ((Hazard_len == 0) ? 0 : int'(Hazard_len) - 1) : m_pend - 1;
        m_bub++;
      end else begin
        m_ctrl[0] = in_ctrl;
        m_valid[0] = in_valid;
      end
    end
  endtask
  task automatic check_outputs(input string tag);
    for (int k = 0; k < S; k++) begin
      chk($sformatf("%s_ctrl%0d", tag, k), 64'(out_ctrl[k*W +: W]), 64'(m_ctrl[k]));
      chk($sformatf("%s_valid%0d", tag, k), 64'(out_valid[k]), 64'(m_valid[k]));
    end
`ifdef CTRL_PIPE_STATS_EN
    chk($sformatf("%s_bubble_cnt", tag), 64'(bubble_cnt), 64'(m_bub));
`endif
  endtask
  task automatic cycle(input string tag, output logic st);
    #3;
    st = Stall;
    chk({tag, "_stall"}, 64'(Stall), 64'(Freeze || (m_pend > 0) || Hazard));
    @(posedge Clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask
  initial begin
    logic st;
    tbl[0]  = '{16'hA5A5, 1, 0, 0, 3'b000, 0, 0, 16'hA5A5, 3'b001};
    tbl[1]  = '{16'h0000, 0, 0, 0, 3'b000, 0, 0, 16'h0000, 3'b010};
    tbl[2]  = '{16'h0000, 0, 0, 0, 3'b000, 0, 0, 16'h0000, 3'b100};
    tbl[3]  = '{16'h1111, 1, 0, 0, 3'b000, 0, 0, 16'h1111, 3'b001};
    tbl[4]  = '{16'h2222, 1, 1, 3, 3'b000, 0, 1, 16'h0000, 3'b010};
    tbl[5]  = '{16'h2222, 1, 0, 0, 3'b000, 0, 1, 16'h0000, 3'b100};
    tbl[6]  = '{16'h2222, 1, 0, 0, 3'b000, 0, 1, 16'h0000, 3'b000};
    tbl[7]  = '{16'h2222, 1, 0, 0, 3'b000, 0, 0, 16'h2222, 3'b001};
    tbl[8]  = '{16'h3333, 1, 1, 4, 3'b000, 0, 1, 16'h0000, 3'b010};
    tbl[9]  = '{16'h3333, 1, 0, 0, 3'b000, 0, 1, 16'h0000, 3'b100};
    tbl[10] = '{16'h3333, 1, 0, 0, 3'b000, 1, 1, 16'h0000, 3'b100};
    tbl[11] = '{16'h3333, 1, 0, 0, 3'b000, 1, 1, 16'h0000, 3'b100};
    tbl[12] = '{16'h3333, 1, 0, 0, 3'b000, 0, 1, 16'h0000, 3'b000};
    tbl[13] = '{16'h3333, 1, 0, 0, 3'b000, 0, 1, 16'h0000, 3'b000};
    tbl[14] = '{16'h3333, 1, 0, 0, 3'b000, 0, 0, 16'h3333, 3'b001};
    tbl[15] = '{16'h4444, 1, 1, 5, 3'b000, 0, 1, 16'h0000, 3'b010};
    tbl[16] = '{16'h4444, 1, 0, 0, 3'b001, 0, 1, 16'h0000, 3'b100};
    tbl[17] = '{16'h4444, 1, 0, 0, 3'b000, 0, 0, 16'h4444, 3'b001};
    tbl[18] = '{16'h5555, 1, 1, 0, 3'b000, 0, 1, 16'h0000, 3'b010};
    tbl[19] = '{16'h5555, 1, 0, 0, 3'b000, 0, 0, 16'h5555, 3'b101};
    tbl[20] = '{16'h6666, 1, 1, 3, 3'b001, 0, 1, 16'h0000, 3'b010};
    tbl[21] = '{16'h6666, 1, 0, 0, 3'b000, 0, 0, 16'h6666, 3'b101};
    model_reset();
    #2;
    check_outputs("reset");
    chk("reset_stall", 64'(Stall), 64'(0));
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    for (int i = 0; i < 22; i++) begin
      in_ctrl = tbl[i].c;
      in_valid = tbl[i].v;
      Hazard = tbl[i].h;
      Hazard_len = tbl[i].len;
      Flush = tbl[i].fl;
      Freeze = tbl[i].fz;
      cycle($sformatf("row%0d", i), st);
      chk($sformatf("row%0d_tbl_stall", i), 64'(st), 64'(tbl[i].es));
      chk($sformatf("row%0d_tbl_c0", i), 64'(out_ctrl[W-1:0]), 64'(tbl[i].ec));
      chk($sformatf("row%0d_tbl_valid", i), 64'(out_valid), 64'(tbl[i].ev));
`ifdef CTRL_PIPE_STATS_EN
      if (i == 6) chk("three_bubble_cnt", 64'(bubble_cnt), 64'(3));
`endif
    end
    in_ctrl = 16'h7777;
    in_valid = 1'b1;
    Flush = '0;
    Freeze = 1'b0;
    Hazard = 1'b1;
    Hazard_len = 3'd5;
    cycle("midrst_a", st);
    Hazard = 1'b0;
    cycle("midrst_b", st);
    #2;
    Rst = 1'b0;
    #1;
    model_reset();
    chk("midrst_stall", 64'(Stall), 64'(0));
    chk("midrst_ctrl", 64'(out_ctrl), 64'(0));
    chk("midrst_valid", 64'(out_valid), 64'(0));
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    cycle("post_rst", st);
    chk("post_rst_c0", 64'(out_ctrl[W-1:0]), 64'(16'h7777));
    for (int i = 0; i < 600; i++) begin
      in_ctrl = W'($urandom);
      in_valid = 1'($urandom);
      Hazard = ($urandom_range(0, 3) == 0);
      Hazard_len = L'($urandom);
      Freeze = ($urandom_range(0, 6) == 0);
      for (int k = 0; k < S; k++) Flush[k] = ($urandom_range(0, 9) == 0);
      cycle($sformatf("rnd%0d", i), st);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
